// File: rtl/bitbang_pkg.sv
// Shared constants and command decode for the multi-channel bitbang configuration port.
package bitbang_pkg;

  localparam int          CTRL_W     = 16;
  localparam logic [11:0] CTRL_MAGIC = 12'hFAB;
  localparam logic [3:0]  CMD_OFF    = 4'h0;
  localparam logic [3:0]  CMD_RDBK   = 4'hE;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_OFF,
    ACT_LOAD,
    ACT_RDBK
  } act_e;

  // Commands above the channel count (other than readback) are silently dropped.
  function automatic act_e decode_cmd(input logic [3:0] cmd, input int num_ch);
    act_e act;
    act = ACT_NONE;
    if (cmd == CMD_OFF)
      act = ACT_OFF;
    else if (cmd == CMD_RDBK)
      act = ACT_RDBK;
    else if (int'(cmd) <= num_ch)
      act = ACT_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/bitbang_edge_sync.sv
// Samples the asynchronous serial pins into clk and produces masked rise/fall strobes.
module bitbang_edge_sync #(
  parameter int SYNC_STAGES = 4
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_s_clk,
  input  logic i_s_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_sd_old
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sc;
  logic [SYNC_STAGES-1:0] r_sd;
  logic [CNT_W-1:0]       r_warm;
  logic                   w_ready;

  assign w_ready = (r_warm == CNT_W'(SYNC_STAGES));

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_sc   <= '0;
      r_sd   <= '0;
      r_warm <= '0;
    end else begin
      r_sc <= {r_sc[SYNC_STAGES-2:0], i_s_clk};
      r_sd <= {r_sd[SYNC_STAGES-2:0], i_s_data};
      if (!w_ready)
        r_warm <= r_warm + CNT_W'(1);
    end
  end

  // Chains fill from zero after reset; masking hides the fake edge a high pin would cause.
  assign o_rise   = w_ready & ~r_sc[SYNC_STAGES-1] &  r_sc[SYNC_STAGES-2];
  assign o_fall   = w_ready &  r_sc[SYNC_STAGES-1] & ~r_sc[SYNC_STAGES-2];
  assign o_sd_old = r_sd[SYNC_STAGES-1];

endmodule

// File: rtl/bitbang_mc.sv
// Bitbang configuration port: data on s_clk rises, control on falls, per-channel loads and readback.
module bitbang_mc
  import bitbang_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 1,
  parameter int SYNC_STAGES = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_clk,
  input  logic                     s_data,
  output logic                     s_dout,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        strobe,
  output logic                     active,
  input  logic [DATA_W-1:0]        rd_data
);

  logic                     w_rise;
  logic                     w_fall;
  logic                     w_sd_old;
  logic [DATA_W-1:0]        r_data_sr;
  logic [CTRL_W-1:0]        r_ctrl_sr;
  logic [DATA_W-1:0]        r_rd_sr;
  logic                     r_hit_q;
  logic                     r_active;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic [NUM_CH-1:0]        r_strobe;
  logic [NUM_CH-1:0]        w_strobe_nxt;
  logic                     w_hit;
  logic                     w_new_hit;
  logic [3:0]               w_cmd;
  logic [3:0]               w_ch;
  act_e                     w_act;

  bitbang_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (clk),
    .i_resetn(resetn),
    .i_s_clk (s_clk),
    .i_s_data(s_data),
    .o_rise  (w_rise),
    .o_fall  (w_fall),
    .o_sd_old(w_sd_old)
  );

  // A command acts only on the cycle the control word first matches.
  assign w_hit        = (r_ctrl_sr[CTRL_W-1:4] == CTRL_MAGIC);
  assign w_cmd        = r_ctrl_sr[3:0];
  assign w_new_hit    = w_hit & ~r_hit_q;
  assign w_act        = w_new_hit ? decode_cmd(w_cmd, NUM_CH) : ACT_NONE;
  assign w_ch         = w_cmd - 4'd1;
  assign w_strobe_nxt = (w_act == ACT_LOAD) ? (NUM_CH'(1) << w_ch) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_sr <= '0;
      r_ctrl_sr <= '0;
      r_rd_sr   <= '0;
      r_hit_q   <= 1'b0;
      r_active  <= 1'b0;
      r_strobe  <= '0;
    end else begin
      r_hit_q  <= w_hit;
      r_strobe <= w_strobe_nxt;
      if (w_rise)
        r_data_sr <= {r_data_sr[DATA_W-2:0], w_sd_old};
      if (w_fall)
        r_ctrl_sr <= {r_ctrl_sr[CTRL_W-2:0], w_sd_old};
      if (w_act == ACT_OFF)
        r_active <= 1'b0;
      else if (w_act == ACT_LOAD)
        r_active <= 1'b1;
      // Capture beats a coincident shift so the first readback bit is never lost.
      if (w_act == ACT_RDBK)
        r_rd_sr <= rd_data;
      else if (w_rise)
        r_rd_sr <= {r_rd_sr[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_strobe_nxt[k])
          r_data[k*DATA_W +: DATA_W] <= r_data_sr;
      end
    end
  end

  assign data   = r_data;
  assign strobe = r_strobe;
  assign active = r_active;
  assign s_dout = r_rd_sr[DATA_W-1];

endmodule
